untrusted_addr_filter: RTL and testbench

UNTRUSTED_ADDR_FILTER -- requirements
Module: untrusted_addr_filter

---
 rtl/untrusted_addr_filter.sv | 173 +++++++++++++++++
 tb/tb_untrusted_addr_filter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/untrusted_addr_filter.sv
// Address/permission firewall between an untrusted requester and a downstream target.
// Denied requests are answered locally with an error and logged in a sticky violation record.
module untrusted_addr_filter #(
   parameter int unsigned NumWindows = 2,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned CntWidth   = 16,
   parameter logic [NumWindows-1:0][AddrWidth-1:0] WinBase = {32'h5000_0000, 32'h0000_0000},
   parameter logic [NumWindows-1:0][AddrWidth-1:0] WinMask = {32'h0001_ffff, 32'h0000_3fff}
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // upstream request
   input  logic                  up_req_valid_i,
   output logic                  up_req_ready_o,
   input  logic [AddrWidth-1:0]  up_req_addr_i,
   input  logic                  up_req_we_i,
   // downstream request
   output logic                  dn_req_valid_o,
   input  logic                  dn_req_ready_i,
   output logic [AddrWidth-1:0]  dn_req_addr_o,
   output logic                  dn_req_we_o,
   // downstream response
   input  logic                  dn_rsp_valid_i,
   input  logic                  dn_rsp_err_i,
   input  logic [DataWidth-1:0]  dn_rsp_data_i,
   // upstream response
   output logic                  up_rsp_valid_o,
   output logic                  up_rsp_err_o,
   output logic [DataWidth-1:0]  up_rsp_data_o,
   // permissions
   input  logic [NumWindows-1:0] win_rd_en_i,
   input  logic [NumWindows-1:0] win_wr_en_i,
   // violation status
   input  logic                  viol_clr_i,
   output logic [CntWidth-1:0]   viol_cnt_o,
   output logic                  viol_valid_o,
   output logic [AddrWidth-1:0]  viol_addr_o,
   output logic                  viol_we_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RSP
   } state_e;

   state_e               state_q, state_d;
   logic                 hit_c;
   logic                 allowed_c;
   logic                 viol_c;

   logic                 rsp_valid_d;
   logic                 rsp_err_d;
   logic [DataWidth-1:0] rsp_data_d;

   logic [CntWidth-1:0]  cnt_d;
   logic                 viol_valid_d;
   logic [AddrWidth-1:0] viol_addr_d;
   logic                 viol_we_d;

   assign dn_req_addr_o = up_req_addr_i;
   assign dn_req_we_o   = up_req_we_i;

   // Window decode: lowest matching index decides the permission bit.
   always_comb begin
      hit_c     = 1'b0;
      allowed_c = 1'b0;
      for (int unsigned i = 0; i < NumWindows; i++) begin
         if (!hit_c && ((up_req_addr_i & ~WinMask[i]) == (WinBase[i] & ~WinMask[i]))) begin
            hit_c     = 1'b1;
            allowed_c = up_req_we_i ? win_wr_en_i[i] : win_rd_en_i[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake steering and next registered response.
   always_comb begin
      state_d        = state_q;
      dn_req_valid_o = 1'b0;
      up_req_ready_o = 1'b0;
      viol_c         = 1'b0;
      rsp_valid_d    = 1'b0;
      rsp_err_d      = 1'b0;
      rsp_data_d     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (allowed_c) begin
               dn_req_valid_o = up_req_valid_i;
               up_req_ready_o = dn_req_ready_i;
               if (up_req_valid_i && dn_req_ready_i) begin
                  state_d = ST_WAIT;
               end
            end else begin
               up_req_ready_o = 1'b1;
               if (up_req_valid_i) begin
                  state_d     = ST_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  viol_c      = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (dn_rsp_valid_i) begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = dn_rsp_err_i;
               rsp_data_d  = dn_rsp_data_i;
            end
         end
         ST_RSP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Violation record: clear first so a coincident violation is captured fresh.
   always_comb begin
      cnt_d        = viol_cnt_o;
      viol_valid_d = viol_valid_o;
      viol_addr_d  = viol_addr_o;
      viol_we_d    = viol_we_o;
      if (viol_clr_i) begin
         cnt_d        = '0;
         viol_valid_d = 1'b0;
         viol_addr_d  = '0;
         viol_we_d    = 1'b0;
      end
      if (viol_c) begin
         if (cnt_d != '1) begin
            cnt_d = cnt_d + CntWidth'(1);
         end
         if (!viol_valid_d) begin
            viol_valid_d = 1'b1;
            viol_addr_d  = up_req_addr_i;
            viol_we_d    = up_req_we_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         up_rsp_valid_o <= 1'b0;
         up_rsp_err_o   <= 1'b0;
         up_rsp_data_o  <= '0;
         viol_cnt_o     <= '0;
         viol_valid_o   <= 1'b0;
         viol_addr_o    <= '0;
         viol_we_o      <= 1'b0;
      end else begin
         up_rsp_valid_o <= rsp_valid_d;
         up_rsp_err_o   <= rsp_err_d;
         up_rsp_data_o  <= rsp_data_d;
         viol_cnt_o     <= cnt_d;
         viol_valid_o   <= viol_valid_d;
         viol_addr_o    <= viol_addr_d;
         viol_we_o      <= viol_we_d;
      end
   end

endmodule

// File: tb/tb_untrusted_addr_filter.sv
// Scoreboard bench for untrusted_addr_filter: directed scenarios then randomized traffic,
// with a second instance (2-bit counter) sharing stimulus to observe saturation.
module tb_untrusted_addr_filter;

   localparam int unsigned NW = 2;
   localparam logic [31:0] W_BASE [NW] = '{32'h0000_0000, 32'h5000_0000};
   localparam logic [31:0] W_SIZE [NW] = '{32'h0000_4000, 32'h0002_0000};

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        up_req_valid_i = 1'b0;
   logic        up_req_ready_o;
   logic [31:0] up_req_addr_i = '0;
   logic        up_req_we_i = 1'b0;
   logic        dn_req_valid_o;
   logic        dn_req_ready_i = 1'b1;
   logic [31:0] dn_req_addr_o;
   logic        dn_req_we_o;
   logic        dn_rsp_valid_i = 1'b0;
   logic        dn_rsp_err_i = 1'b0;
   logic [31:0] dn_rsp_data_i = '0;
   logic        up_rsp_valid_o;
   logic        up_rsp_err_o;
   logic [31:0] up_rsp_data_o;
   logic [1:0]  win_rd_en_i = '0;
   logic [1:0]  win_wr_en_i = '0;
   logic        viol_clr_i = 1'b0;
   logic [15:0] viol_cnt_o;
   logic        viol_valid_o;
   logic [31:0] viol_addr_o;
   logic        viol_we_o;

   logic        d2_up_req_ready, d2_dn_req_valid, d2_dn_req_we;
   logic [31:0] d2_dn_req_addr;
   logic        d2_up_rsp_valid, d2_up_rsp_err;
   logic [31:0] d2_up_rsp_data;
   logic [1:0]  d2_viol_cnt;
   logic        d2_viol_valid, d2_viol_we;
   logic [31:0] d2_viol_addr;

   untrusted_addr_filter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .up_req_valid_i(up_req_valid_i), .up_req_ready_o(up_req_ready_o),
      .up_req_addr_i(up_req_addr_i), .up_req_we_i(up_req_we_i),
      .dn_req_valid_o(dn_req_valid_o), .dn_req_ready_i(dn_req_ready_i),
      .dn_req_addr_o(dn_req_addr_o), .dn_req_we_o(dn_req_we_o),
      .dn_rsp_valid_i(dn_rsp_valid_i), .dn_rsp_err_i(dn_rsp_err_i), .dn_rsp_data_i(dn_rsp_data_i),
      .up_rsp_valid_o(up_rsp_valid_o), .up_rsp_err_o(up_rsp_err_o), .up_rsp_data_o(up_rsp_data_o),
      .win_rd_en_i(win_rd_en_i), .win_wr_en_i(win_wr_en_i),
      .viol_clr_i(viol_clr_i), .viol_cnt_o(viol_cnt_o), .viol_valid_o(viol_valid_o),
      .viol_addr_o(viol_addr_o), .viol_we_o(viol_we_o)
   );

   untrusted_addr_filter #(.CntWidth(2)) dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .up_req_valid_i(up_req_valid_i), .up_req_ready_o(d2_up_req_ready),
      .up_req_addr_i(up_req_addr_i), .up_req_we_i(up_req_we_i),
      .dn_req_valid_o(d2_dn_req_valid), .dn_req_ready_i(dn_req_ready_i),
      .dn_req_addr_o(d2_dn_req_addr), .dn_req_we_o(d2_dn_req_we),
      .dn_rsp_valid_i(dn_rsp_valid_i), .dn_rsp_err_i(dn_rsp_err_i), .dn_rsp_data_i(dn_rsp_data_i),
      .up_rsp_valid_o(d2_up_rsp_valid), .up_rsp_err_o(d2_up_rsp_err), .up_rsp_data_o(d2_up_rsp_data),
      .win_rd_en_i(win_rd_en_i), .win_wr_en_i(win_wr_en_i),
      .viol_clr_i(viol_clr_i), .viol_cnt_o(d2_viol_cnt), .viol_valid_o(d2_viol_valid),
      .viol_addr_o(d2_viol_addr), .viol_we_o(d2_viol_we)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        err;
      logic [31:0] data;
      bit          allowed;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   longint      m_cnt = 0;
   bit          m_valid = 0;
   logic [31:0] m_addr = '0;
   bit          m_we = 0;

   function automatic bit model_allowed(input logic [31:0] a, input bit we,
                                        input logic [1:0] rd, input logic [1:0] wr);
      for (int i = 0; i < NW; i++) begin
         if (a >= W_BASE[i] && a < W_BASE[i] + W_SIZE[i]) return we ? wr[i] : rd[i];
      end
      return 1'b0;
   endfunction

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_step(input bit viol, input logic [31:0] a, input bit we, input bit clr);
      if (clr) begin
         m_cnt = 0; m_valid = 0; m_addr = '0; m_we = 0;
      end
      if (viol) begin
         m_cnt++;
         if (!m_valid) begin
            m_valid = 1; m_addr = a; m_we = we;
         end
      end
   endtask

   // ---------------- downstream responder ----------------
   int          cur_dly = 0;
   logic        cur_err = 0;
   logic [31:0] cur_data = '0;
   int          rsp_due = -1;
   bit          spur_en = 0;

   initial begin
      bit          pending;
      int          cnt;
      logic        r_err;
      logic [31:0] r_data;
      pending = 0; cnt = 0; r_err = 0; r_data = '0;
      forever begin
         @(negedge clk_i);
         if (rst_ni && dn_req_valid_o && dn_req_ready_i) begin
            pending = 1; cnt = cur_dly; r_err = cur_err; r_data = cur_data;
         end
         @(posedge clk_i); #1;
         dn_rsp_valid_i = 1'b0;
         dn_rsp_err_i   = 1'($urandom);
         dn_rsp_data_i  = $urandom;
         if (pending) begin
            if (cnt == 0) begin
               dn_rsp_valid_i = 1'b1; dn_rsp_err_i = r_err; dn_rsp_data_i = r_data;
               rsp_due = cyc + 1; pending = 0;
            end else begin
               cnt--;
            end
         end else if (spur_en && $urandom_range(0, 5) == 0) begin
            dn_rsp_valid_i = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk_i) begin
      if (rst_ni) begin
         check("viol_cnt", 64'(viol_cnt_o), 64'(sat(m_cnt, 65535)));
         check("viol_cnt_sat2", 64'(d2_viol_cnt), 64'(sat(m_cnt, 3)));
         check("viol_valid", 64'(viol_valid_o), 64'(m_valid));
         check("viol_addr", 64'(viol_addr_o), 64'(m_addr));
         check("viol_we", 64'(viol_we_o), 64'(m_we));
         if (up_rsp_valid_o) begin
            check("ready_in_rsp", 64'(up_req_ready_o), 64'd0);
            check("rsp_expected", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_err", 64'(up_rsp_err_o), 64'(e.err));
               check("rsp_data", 64'(up_rsp_data_o), 64'(e.data));
               check("rsp_cycle", 64'(cyc), 64'(e.allowed ? rsp_due : e.due));
            end
         end else begin
            check("rsp_data_idle", 64'(up_rsp_data_o), 64'd0);
         end
      end
   end

   // ---------------- driver ----------------
   bit rnd_clr = 0;

   task automatic issue(input logic [31:0] a, input bit we, input logic [1:0] rd,
                        input logic [1:0] wr, input int dly, input bit err,
                        input logic [31:0] data, input bit clr_acc);
      bit   ok, allowed;
      int   n;
      exp_t e;
      allowed = model_allowed(a, we, rd, wr);
      up_req_valid_i = 1'b1; up_req_addr_i = a; up_req_we_i = we;
      win_rd_en_i = rd; win_wr_en_i = wr;
      cur_dly = dly; cur_err = err; cur_data = data;
      ok = 0; n = 0;
      while (!ok && n < 60) begin
         @(negedge clk_i);
         ok = up_req_ready_o;
         if (ok) begin
            check("dn_req_valid", 64'(dn_req_valid_o), 64'(allowed));
            if (allowed) begin
               check("dn_req_addr", 64'(dn_req_addr_o), 64'(a));
               check("dn_req_we", 64'(dn_req_we_o), 64'(we));
            end
         end
         viol_clr_i = (ok && clr_acc) || (rnd_clr && $urandom_range(0, 15) == 0);
         @(posedge clk_i); #1;
         model_step(ok && !allowed, a, we, viol_clr_i);
         viol_clr_i = 1'b0;
         dn_req_ready_i = ($urandom_range(0, 3) != 0);
         n++;
      end
      check("req_accepted", 64'(ok), 64'd1);
      up_req_valid_i = 1'b0;
      if (ok) begin
         check("one_outstanding", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         e.err = allowed ? err : 1'b1;
         e.data = allowed ? data : 32'h0;
         e.allowed = allowed;
         e.due = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         win_rd_en_i = 2'($urandom); win_wr_en_i = 2'($urandom);
         up_req_addr_i = $urandom; up_req_we_i = 1'($urandom);
         viol_clr_i = rnd_clr && ($urandom_range(0, 7) == 0);
         @(posedge clk_i); #1;
         model_step(0, '0, 0, viol_clr_i);
         viol_clr_i = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] edges [6] = '{32'h0000_3fff, 32'h0000_4000, 32'h4fff_ffff,
                                 32'h5000_0000, 32'h5001_ffff, 32'h5002_0000};
      case ($urandom_range(0, 4))
         0: return $urandom & 32'h0000_3fff;
         1: return 32'h5000_0000 | ($urandom & 32'h0001_ffff);
         2: return $urandom;
         default: return edges[$urandom_range(0, 5)];
      endcase
   endfunction

   initial begin
      // reset state
      @(posedge clk_i); #1;
      check("rst_rsp_valid", 64'(up_rsp_valid_o), 64'd0);
      check("rst_viol_cnt", 64'(viol_cnt_o), 64'd0);
      check("rst_viol_valid", 64'(viol_valid_o), 64'd0);
      @(posedge clk_i); #3 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // allowed read through window 0
      issue(32'h0000_1000, 0, 2'b01, 2'b00, 3, 0, 32'hCAFE_F00D, 0);
      wait_done();
      check("t034_cnt", 64'(viol_cnt_o), 64'd0);

      // denied write to window 1
      issue(32'h5000_0010, 1, 2'b11, 2'b00, 0, 0, 32'h0, 0);
      wait_done();
      check("t035_cnt", 64'(viol_cnt_o), 64'd1);
      check("t035_addr", 64'(viol_addr_o), 64'h5000_0010);
      check("t035_we", 64'(viol_we_o), 64'd1);

      // explicit clear, then two misses: first address sticks
      viol_clr_i = 1'b1;
      @(posedge clk_i); #1;
      model_step(0, '0, 0, 1);
      viol_clr_i = 1'b0;
      issue(32'h6000_0000, 0, 2'b11, 2'b11, 0, 0, 32'h0, 0);
      issue(32'h0000_4000, 0, 2'b11, 2'b11, 0, 0, 32'h0, 0);
      wait_done();
      check("t036_cnt", 64'(viol_cnt_o), 64'd2);
      check("t036_addr", 64'(viol_addr_o), 64'h6000_0000);

      // five more denials: narrow counter saturates
      for (int k = 0; k < 5; k++) issue(32'h7000_0100 + 32'(k), 0, 2'b11, 2'b11, 0, 0, 32'h0, 0);
      wait_done();
      check("t037_sat", 64'(d2_viol_cnt), 64'd3);

      // clear coincident with a denial
      issue(32'h7000_0000, 0, 2'b11, 2'b11, 0, 0, 32'h0, 1);
      wait_done();
      check("t038_cnt", 64'(viol_cnt_o), 64'd1);
      check("t038_addr", 64'(viol_addr_o), 64'h7000_0000);

      // window edges
      issue(32'h0000_3fff, 0, 2'b01, 2'b00, 1, 1, 32'h1111_2222, 0);
      issue(32'h5001_ffff, 1, 2'b00, 2'b10, 2, 0, 32'h3333_4444, 0);
      issue(32'h5002_0000, 1, 2'b11, 2'b11, 0, 0, 32'h0, 0);
      issue(32'h4fff_ffff, 0, 2'b11, 2'b11, 0, 0, 32'h0, 0);
      wait_done();

      // reset while waiting on downstream; late response must be dropped
      issue(32'h0000_0200, 0, 2'b01, 2'b00, 8, 0, 32'hDEAD_BEEF, 0);
      @(posedge clk_i); @(posedge clk_i); #3;
      rst_ni = 1'b0;
      #1;
      exp_q.delete();
      model_step(0, '0, 0, 1);
      check("t039_rsp_valid", 64'(up_rsp_valid_o), 64'd0);
      check("t039_cnt", 64'(viol_cnt_o), 64'd0);
      check("t039_valid", 64'(viol_valid_o), 64'd0);
      check("t039_addr", 64'(viol_addr_o), 64'd0);
      @(posedge clk_i); #3 rst_ni = 1'b1;
      repeat (15) begin
         @(posedge clk_i); #1;
      end
      check("t039_no_rsp", 64'(up_rsp_valid_o), 64'd0);
      issue(32'h0000_0300, 0, 2'b01, 2'b00, 1, 0, 32'h5555_AAAA, 0);
      wait_done();

      // randomized traffic
      rnd_clr = 1; spur_en = 1;
      for (int t = 0; t < 300; t++) begin
         issue(rand_addr(), 1'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 4),
               1'($urandom), $urandom, 0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      wait_done();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
